// File: rtl/alu_seq_if.sv
// Request/response bundle between the register-file side and alu_seq.
// The requester drives the operands and START; the ALU returns the result,
// flags and handshake status.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       sel;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_hi;
    logic [3:0]       flags;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, a, b, sel,
        input  out, out_hi, flags, busy, done, err
    );

    modport slave (
        input  start, a, b, sel,
        output out, out_hi, flags, busy, done, err
    );
endinterface

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with a START/BUSY/DONE handshake.
// Single-cycle ops register their result on the accepting edge; MUL runs an
// iterative shift-add over WIDTH cycles followed by one FIN cycle that
// publishes the 2*WIDTH-bit product. FLAGS = {N, V, C, Z}.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input logic      CLK,
    input logic      RST_N,
    alu_seq_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_INC  = 4'd8;
    localparam logic [3:0] OP_DEC  = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;
    localparam logic [3:0] OP_CMP  = 4'd11;
    localparam logic [3:0] OP_PASS = 4'd12;

    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t             state_r, state_s;
    logic [WIDTH-1:0]   mcand_r, mcand_s;
    logic [WIDTH-1:0]   mplier_r, mplier_s;
    logic [2*WIDTH-1:0] acc_r, acc_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [WIDTH-1:0]   out_r, out_s;
    logic [WIDTH-1:0]   out_hi_r, out_hi_s;
    logic [3:0]         flags_r, flags_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic               err_r, err_s;

    logic [WIDTH:0]     add_s, sub_s, inc_s, dec_s, mul_sum_s;
    logic [WIDTH-1:0]   alu_res_s;
    logic [3:0]         alu_flags_s;
    logic               alu_err_s, alu_keep_out_s;
    logic               take_single_s, take_mul_s;

    // Pack {N, V, C, Z} for a WIDTH-bit result.
    function automatic logic [3:0] make_flags(input logic [WIDTH-1:0] res,
                                              input logic v, input logic c);
        return {res[WIDTH-1], v, c, (res == {WIDTH{1'b0}})};
    endfunction

    // Signed overflow of x + y: operands agree in sign, result does not.
    function automatic logic add_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                     input logic [WIDTH-1:0] r);
        return (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    endfunction

    // Signed overflow of x - y: operands differ in sign, result sign differs from x.
    function automatic logic sub_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                     input logic [WIDTH-1:0] r);
        return (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    endfunction

    // Single-cycle result and flags for the opcode currently presented.
    always_comb begin
        add_s          = {1'b0, bus.a} + {1'b0, bus.b};
        sub_s          = {1'b0, bus.a} - {1'b0, bus.b};
        inc_s          = {1'b0, bus.a} + {1'b0, ONE};
        dec_s          = {1'b0, bus.a} - {1'b0, ONE};
        alu_res_s      = {WIDTH{1'b0}};
        alu_flags_s    = 4'b0000;
        alu_err_s      = 1'b0;
        alu_keep_out_s = 1'b0;
        case (bus.sel)
            OP_ADD: begin
                alu_res_s   = add_s[WIDTH-1:0];
                alu_flags_s = make_flags(alu_res_s, add_ovf(bus.a, bus.b, alu_res_s), add_s[WIDTH]);
            end
            OP_SUB: begin
                alu_res_s   = sub_s[WIDTH-1:0];
                alu_flags_s = make_flags(alu_res_s, sub_ovf(bus.a, bus.b, alu_res_s), sub_s[WIDTH]);
            end
            OP_AND: begin
                alu_res_s   = bus.a & bus.b;
                alu_flags_s = make_flags(alu_res_s, 1'b0, 1'b0);
            end
            OP_OR: begin
                alu_res_s   = bus.a | bus.b;
                alu_flags_s = make_flags(alu_res_s, 1'b0, 1'b0);
            end
            OP_XOR: begin
                alu_res_s   = bus.a ^ bus.b;
                alu_flags_s = make_flags(alu_res_s, 1'b0, 1'b0);
            end
            OP_NOT: begin
                alu_res_s   = ~bus.a;
                alu_flags_s = make_flags(alu_res_s, 1'b0, 1'b0);
            end
            OP_SHL: begin
                alu_res_s   = {bus.a[WIDTH-2:0], 1'b0};
                alu_flags_s = make_flags(alu_res_s, 1'b0, bus.a[WIDTH-1]);
            end
            OP_SHR: begin
                alu_res_s   = {1'b0, bus.a[WIDTH-1:1]};
                alu_flags_s = make_flags(alu_res_s, 1'b0, bus.a[0]);
            end
            OP_INC: begin
                alu_res_s   = inc_s[WIDTH-1:0];
                alu_flags_s = make_flags(alu_res_s, add_ovf(bus.a, ONE, alu_res_s), inc_s[WIDTH]);
            end
            OP_DEC: begin
                alu_res_s   = dec_s[WIDTH-1:0];
                alu_flags_s = make_flags(alu_res_s, sub_ovf(bus.a, ONE, alu_res_s), dec_s[WIDTH]);
            end
            OP_MUL: begin
                alu_res_s = {WIDTH{1'b0}};
            end
            OP_CMP: begin
                // Flags come from the difference, but OUT is left untouched.
                alu_res_s      = sub_s[WIDTH-1:0];
                alu_flags_s    = make_flags(alu_res_s, sub_ovf(bus.a, bus.b, alu_res_s), sub_s[WIDTH]);
                alu_keep_out_s = 1'b1;
            end
            OP_PASS: begin
                alu_res_s   = bus.b;
                alu_flags_s = make_flags(alu_res_s, 1'b0, 1'b0);
            end
            default: begin
                alu_err_s = 1'b1;
            end
        endcase
    end

    // Next-state and next-register values for the handshake FSM and multiplier.
    always_comb begin
        state_s  = state_r;
        mcand_s  = mcand_r;
        mplier_s = mplier_r;
        acc_s    = acc_r;
        cnt_s    = cnt_r;
        out_s    = out_r;
        out_hi_s = out_hi_r;
        flags_s  = flags_r;
        busy_s   = busy_r;
        done_s   = 1'b0;
        err_s    = 1'b0;

        mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                  + (mplier_r[0] ? {1'b0, mcand_r} : {(WIDTH + 1){1'b0}});

        // A new multiply may also start in FIN, on the edge that publishes the
        // previous product. A single-cycle op there would collide with that
        // publication, so only IDLE accepts single-cycle ops.
        take_single_s = (state_r == ST_IDLE) && bus.start && (bus.sel != OP_MUL);
        take_mul_s    = ((state_r == ST_IDLE) || (state_r == ST_FIN)) && bus.start
                        && (bus.sel == OP_MUL);

        case (state_r)
            ST_IDLE: begin
                if (take_single_s) begin
                    if (alu_keep_out_s) begin
                        out_s = out_r;
                    end else begin
                        out_s = alu_res_s;
                    end
                    out_hi_s = {WIDTH{1'b0}};
                    flags_s  = alu_flags_s;
                    err_s    = alu_err_s;
                    done_s   = 1'b1;
                    state_s  = ST_IDLE;
                end else if (take_mul_s) begin
                    mcand_s  = bus.a;
                    mplier_s = bus.b;
                    acc_s    = {(2*WIDTH){1'b0}};
                    cnt_s    = {CNT_W{1'b0}};
                    busy_s   = 1'b1;
                    state_s  = ST_MUL;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                // Add into the upper half (carry kept in the shifted-in bit), then shift right.
                acc_s    = {mul_sum_s, acc_r[WIDTH-1:1]};
                mplier_s = {1'b0, mplier_r[WIDTH-1:1]};
                cnt_s    = cnt_r + CNT_W'(1);
                if (cnt_r == LAST_ITER) begin
                    state_s = ST_FIN;
                end else begin
                    state_s = ST_MUL;
                end
            end
            ST_FIN: begin
                out_s    = acc_r[WIDTH-1:0];
                out_hi_s = acc_r[2*WIDTH-1:WIDTH];
                flags_s  = {acc_r[2*WIDTH-1], 1'b0, 1'b0, (acc_r == {(2*WIDTH){1'b0}})};
                done_s   = 1'b1;
                if (take_mul_s) begin
                    mcand_s  = bus.a;
                    mplier_s = bus.b;
                    acc_s    = {(2*WIDTH){1'b0}};
                    cnt_s    = {CNT_W{1'b0}};
                    busy_s   = 1'b1;
                    state_s  = ST_MUL;
                end else begin
                    busy_s  = 1'b0;
                    state_s = ST_IDLE;
                end
            end
            default: begin
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and output registers; reset aborts any multiply in flight.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            mcand_r  <= {WIDTH{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            acc_r    <= {(2*WIDTH){1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            out_r    <= {WIDTH{1'b0}};
            out_hi_r <= {WIDTH{1'b0}};
            flags_r  <= 4'b0000;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            mcand_r  <= mcand_s;
            mplier_r <= mplier_s;
            acc_r    <= acc_s;
            cnt_r    <= cnt_s;
            out_r    <= out_s;
            out_hi_r <= out_hi_s;
            flags_r  <= flags_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            err_r    <= err_s;
        end
    end

    assign bus.out    = out_r;
    assign bus.out_hi = out_hi_r;
    assign bus.flags  = flags_r;
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.err    = err_r;
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: an 8-bit and a 16-bit instance, checked
// against an integer-arithmetic reference model of the opcode table.
module tb_alu_seq;
    typedef struct packed {
        logic [7:0] out;
        logic [7:0] hi;
        logic [3:0] flags;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   tests_run    = 0;
    int   tests_failed = 0;
    logic [7:0] exp_out = 8'h00;

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(8))  bus8 ();
    alu_seq_if #(.WIDTH(16)) bus16 ();

    alu_seq #(.WIDTH(8))  dut8  (.CLK(clk), .RST_N(rst_n), .bus(bus8));
    alu_seq #(.WIDTH(16)) dut16 (.CLK(clk), .RST_N(rst_n), .bus(bus16));

    // Reference model: result of one 8-bit op computed with plain integers.
    function automatic exp_t ref8(input logic [3:0] sel, input logic [7:0] a,
                                  input logic [7:0] b, input logic [7:0] prev);
        exp_t e;
        int ia, ib, sa, sb, r, sr, p;
        logic v, c;
        logic [7:0] r8;
        ia = int'(a);
        ib = int'(b);
        sa = (ia >= 128) ? ia - 256 : ia;
        sb = (ib >= 128) ? ib - 256 : ib;
        r = 0; sr = 0; v = 1'b0; c = 1'b0;
        e.hi = 8'h00; e.err = 1'b0; e.out = 8'h00; e.flags = 4'b0000;
        case (sel)
            4'd0:  begin r = ia + ib; sr = sa + sb; c = (r > 255); v = (sr > 127) || (sr < -128); end
            4'd1, 4'd11: begin r = ia - ib; sr = sa - sb; c = (r < 0); v = (sr > 127) || (sr < -128); end
            4'd2:  r = ia & ib;
            4'd3:  r = ia | ib;
            4'd4:  r = ia ^ ib;
            4'd5:  r = 255 - ia;
            4'd6:  begin r = ia * 2; c = (ia >= 128); end
            4'd7:  begin r = ia / 2; c = ((ia % 2) == 1); end
            4'd8:  begin r = ia + 1; sr = sa + 1; c = (r > 255); v = (sr > 127); end
            4'd9:  begin r = ia - 1; sr = sa - 1; c = (r < 0); v = (sr < -128); end
            4'd10: begin
                p = ia * ib;
                e.out = 8'(p % 256);
                e.hi = 8'(p / 256);
                e.flags = {(p >= 32768), 1'b0, 1'b0, (p == 0)};
                return e;
            end
            4'd12: r = ib;
            default: begin e.err = 1'b1; return e; end
        endcase
        r8 = 8'(r & 255);
        e.out = (sel == 4'd11) ? prev : r8;
        e.flags = {(r8 >= 8'd128), v, c, (r8 == 8'h00)};
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one single-cycle op for exactly one edge; START stays high.
    task automatic drive8(input logic [3:0] sel, input logic [7:0] a, input logic [7:0] b);
        bus8.sel = sel; bus8.a = a; bus8.b = b; bus8.start = 1'b1;
        tick();
    endtask

    task automatic mul8_start(input logic [7:0] a, input logic [7:0] b);
        bus8.sel = 4'd10; bus8.a = a; bus8.b = b; bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
    endtask

    // Wait for DONE (bounded), optionally raising START for one cycle at lat==poke_at.
    task automatic mul8_wait(input int poke_at, input logic [3:0] psel, input logic [7:0] pa,
                             input logic [7:0] pb, output int lat, output int bc);
        lat = 0; bc = 0;
        do begin
            if (bus8.busy === 1'b1) bc++;
            if (lat == poke_at) begin
                bus8.sel = psel; bus8.a = pa; bus8.b = pb; bus8.start = 1'b1;
            end else begin
                bus8.start = 1'b0;
            end
            tick();
            lat++;
        end while (bus8.done !== 1'b1 && lat < 64);
        bus8.start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus8.start = 1'b0; bus8.a = 8'h00; bus8.b = 8'h00; bus8.sel = 4'd0;
        bus16.start = 1'b0; bus16.a = 16'h0000; bus16.b = 16'h0000; bus16.sel = 4'd0;
        tick(); tick();
        tests_run++;
        if ({bus8.out, bus8.out_hi, bus8.flags, bus8.busy, bus8.done, bus8.err} !== 23'd0) begin
            tests_failed++;
            $display("FAIL reset8: got out=%h hi=%h flags=%b busy=%b done=%b err=%b, expected all 0",
                     bus8.out, bus8.out_hi, bus8.flags, bus8.busy, bus8.done, bus8.err);
        end
        tests_run++;
        if ({bus16.out, bus16.out_hi, bus16.flags, bus16.busy, bus16.done, bus16.err} !== 39'd0) begin
            tests_failed++;
            $display("FAIL reset16: got out=%h hi=%h flags=%b busy=%b done=%b, expected all 0",
                     bus16.out, bus16.out_hi, bus16.flags, bus16.busy, bus16.done);
        end
        rst_n = 1'b1;
        exp_out = 8'h00;
        tick();
    endtask

    task automatic test_directed();
        logic [3:0] sels [3]  = '{4'd0, 4'd1, 4'd0};
        logic [7:0] as   [3]  = '{8'h03, 8'h03, 8'h7F};
        logic [7:0] bs   [3]  = '{8'h05, 8'h05, 8'h01};
        logic [7:0] outs [3]  = '{8'h08, 8'hFE, 8'h80};
        logic [3:0] flgs [3]  = '{4'b0000, 4'b1010, 4'b1100};
        for (int i = 0; i < 3; i++) begin
            drive8(sels[i], as[i], bs[i]);
            bus8.start = 1'b0;
            tests_run++;
            if ({bus8.done, bus8.err, bus8.out, bus8.flags} !== {1'b1, 1'b0, outs[i], flgs[i]}) begin
                tests_failed++;
                $display("FAIL directed%0d: got done=%b err=%b out=%h flags=%b, expected done=1 err=0 out=%h flags=%b",
                         i, bus8.done, bus8.err, bus8.out, bus8.flags, outs[i], flgs[i]);
            end
            exp_out = outs[i];
            tick();
            tests_run++;
            if ({bus8.done, bus8.out, bus8.flags} !== {1'b0, outs[i], flgs[i]}) begin
                tests_failed++;
                $display("FAIL hold%0d: got done=%b out=%h flags=%b, expected done=0 out=%h flags=%b",
                         i, bus8.done, bus8.out, bus8.flags, outs[i], flgs[i]);
            end
        end
    endtask

    task automatic test_sweep();
        exp_t e;
        for (int s = 0; s < 16; s++) begin
            if (s != 10) begin
                e = ref8(4'(s), 8'h03, 8'h05, exp_out);
                drive8(4'(s), 8'h03, 8'h05);
                tests_run++;
                if ({bus8.done, bus8.err, bus8.out, bus8.out_hi, bus8.flags} !== {1'b1, e.err, e.out, e.hi, e.flags}) begin
                    tests_failed++;
                    $display("FAIL sweep sel=%0d: got done=%b err=%b out=%h hi=%h flags=%b, expected done=1 err=%b out=%h hi=%h flags=%b",
                             s, bus8.done, bus8.err, bus8.out, bus8.out_hi, bus8.flags, e.err, e.out, e.hi, e.flags);
                end
                exp_out = e.out;
            end
        end
        bus8.start = 1'b0;
        tick();
        tests_run++;
        if (bus8.done !== 1'b0 || bus8.err !== 1'b0) begin
            tests_failed++;
            $display("FAIL sweep_end: got done=%b err=%b, expected 0 0", bus8.done, bus8.err);
        end
    endtask

    task automatic test_mul();
        int lat, bc;
        mul8_start(8'hFF, 8'hFF);
        mul8_wait(3, 4'd0, 8'h11, 8'h22, lat, bc);
        tests_run++;
        if (lat !== 9 || bc !== 9) begin
            tests_failed++;
            $display("FAIL mul_latency: got lat=%0d busy_cycles=%0d, expected 9 9", lat, bc);
        end
        tests_run++;
        if ({bus8.out, bus8.out_hi, bus8.flags, bus8.err, bus8.busy} !== {8'h01, 8'hFE, 4'b1000, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL mul_ffxff: got out=%h hi=%h flags=%b err=%b busy=%b, expected 01 FE 1000 0 0",
                     bus8.out, bus8.out_hi, bus8.flags, bus8.err, bus8.busy);
        end
        exp_out = 8'h01;
        tick();
        tests_run++;
        if ({bus8.done, bus8.out, bus8.out_hi} !== {1'b0, 8'h01, 8'hFE}) begin
            tests_failed++;
            $display("FAIL mul_hold: got done=%b out=%h hi=%h, expected 0 01 FE", bus8.done, bus8.out, bus8.out_hi);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        exp_t e1, e2;
        logic [7:0] a1, b1, a2, b2;
        a1 = 8'($urandom); b1 = 8'($urandom); a2 = 8'($urandom); b2 = 8'($urandom);
        e1 = ref8(4'd10, a1, b1, exp_out);
        e2 = ref8(4'd10, a2, b2, exp_out);
        mul8_start(a1, b1);
        mul8_wait(8, 4'd10, a2, b2, lat, bc);
        tests_run++;
        if ({bus8.out, bus8.out_hi, bus8.flags, bus8.busy} !== {e1.out, e1.hi, e1.flags, 1'b1} || lat !== 9) begin
            tests_failed++;
            $display("FAIL b2b_first: got out=%h hi=%h flags=%b busy=%b lat=%0d, expected %h %h %b busy=1 lat=9",
                     bus8.out, bus8.out_hi, bus8.flags, bus8.busy, lat, e1.out, e1.hi, e1.flags);
        end
        mul8_wait(-1, 4'd0, 8'h00, 8'h00, lat, bc);
        tests_run++;
        if ({bus8.out, bus8.out_hi, bus8.flags} !== {e2.out, e2.hi, e2.flags} || lat !== 9 || bc !== 9) begin
            tests_failed++;
            $display("FAIL b2b_second: got out=%h hi=%h flags=%b lat=%0d busy=%0d, expected %h %h %b lat=9 busy=9",
                     bus8.out, bus8.out_hi, bus8.flags, lat, bc, e2.out, e2.hi, e2.flags);
        end
        exp_out = e2.out;
        // Single-cycle ops back to back must give DONE every cycle.
        for (int i = 0; i < 4; i++) begin
            e1 = ref8(4'd0, 8'(i), 8'h10, exp_out);
            drive8(4'd0, 8'(i), 8'h10);
            tests_run++;
            if (bus8.done !== 1'b1 || bus8.out !== e1.out || bus8.out_hi !== 8'h00) begin
                tests_failed++;
                $display("FAIL b2b_add%0d: got done=%b out=%h hi=%h, expected 1 %h 00", i, bus8.done, bus8.out, bus8.out_hi, e1.out);
            end
            exp_out = e1.out;
        end
        bus8.start = 1'b0;
        tick();
    endtask

    task automatic test_mul_reset();
        int seen;
        mul8_start(8'h12, 8'h34);
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tests_run++;
        if ({bus8.out, bus8.out_hi, bus8.flags, bus8.busy, bus8.done, bus8.err} !== 23'd0) begin
            tests_failed++;
            $display("FAIL mul_abort: got out=%h hi=%h flags=%b busy=%b done=%b, expected all 0",
                     bus8.out, bus8.out_hi, bus8.flags, bus8.busy, bus8.done);
        end
        exp_out = 8'h00;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus8.done === 1'b1 || bus8.busy === 1'b1) seen++;
        end
        tests_run++;
        if (seen !== 0) begin
            tests_failed++;
            $display("FAIL mul_abort_quiet: got %0d cycles with done/busy, expected 0", seen);
        end
        drive8(4'd0, 8'h03, 8'h05);
        bus8.start = 1'b0;
        tests_run++;
        if ({bus8.done, bus8.out, bus8.flags} !== {1'b1, 8'h08, 4'b0000}) begin
            tests_failed++;
            $display("FAIL post_reset_add: got done=%b out=%h flags=%b, expected 1 08 0000", bus8.done, bus8.out, bus8.flags);
        end
        exp_out = 8'h08;
        tick();
    endtask

    task automatic test_random();
        exp_t e;
        int lat, bc;
        logic [3:0] s;
        logic [7:0] a, b;
        for (int i = 0; i < 300; i++) begin
            s = 4'($urandom_range(0, 15));
            a = 8'($urandom);
            b = 8'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                a = 8'h80; b = 8'h7F;
            end
            e = ref8(s, a, b, exp_out);
            if (s == 4'd10) begin
                mul8_start(a, b);
                mul8_wait(-1, 4'd0, 8'h00, 8'h00, lat, bc);
                tests_run++;
                if ({bus8.out, bus8.out_hi, bus8.flags, bus8.err} !== {e.out, e.hi, e.flags, e.err} || lat !== 9 || bc !== 9) begin
                    tests_failed++;
                    $display("FAIL rnd_mul %h*%h: got out=%h hi=%h flags=%b lat=%0d busy=%0d, expected %h %h %b lat=9 busy=9",
                             a, b, bus8.out, bus8.out_hi, bus8.flags, lat, bc, e.out, e.hi, e.flags);
                end
            end else begin
                drive8(s, a, b);
                tests_run++;
                if ({bus8.done, bus8.err, bus8.out, bus8.out_hi, bus8.flags} !== {1'b1, e.err, e.out, e.hi, e.flags}) begin
                    tests_failed++;
                    $display("FAIL rnd sel=%0d a=%h b=%h: got done=%b err=%b out=%h hi=%h flags=%b, expected 1 %b %h %h %b",
                             s, a, b, bus8.done, bus8.err, bus8.out, bus8.out_hi, bus8.flags, e.err, e.out, e.hi, e.flags);
                end
            end
            exp_out = e.out;
            if ($urandom_range(0, 3) == 0) begin
                bus8.start = 1'b0;
                tick();
                tests_run++;
                if (bus8.done !== 1'b0 || bus8.out !== exp_out) begin
                    tests_failed++;
                    $display("FAIL rnd_idle: got done=%b out=%h, expected 0 %h", bus8.done, bus8.out, exp_out);
                end
            end
        end
        bus8.start = 1'b0;
        tick();
    endtask

    task automatic test_w16();
        int lat;
        logic [15:0] a, b;
        longint unsigned p;
        for (int i = 0; i < 8; i++) begin
            if (i == 0) begin
                a = 16'hFFFF; b = 16'h0002;
            end else begin
                a = 16'($urandom); b = 16'($urandom);
            end
            p = longint'(a) * longint'(b);
            bus16.sel = 4'd10; bus16.a = a; bus16.b = b; bus16.start = 1'b1;
            tick();
            bus16.start = 1'b0;
            lat = 0;
            do begin
                tick();
                lat++;
            end while (bus16.done !== 1'b1 && lat < 64);
            tests_run++;
            if (lat !== 17 || bus16.out !== 16'(p) || bus16.out_hi !== 16'(p >> 16)
                || bus16.flags !== {p[31], 1'b0, 1'b0, (p == 0)}) begin
                tests_failed++;
                $display("FAIL w16_mul %h*%h: got lat=%0d out=%h hi=%h flags=%b, expected lat=17 out=%h hi=%h",
                         a, b, lat, bus16.out, bus16.out_hi, bus16.flags, 16'(p), 16'(p >> 16));
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_sweep();
        test_mul();
        test_back_to_back();
        test_mul_reset();
        test_random();
        test_w16();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
